// File: rtl/multiport_regfile.sv
// Two-read/one-write register file with pending-write scoreboard.
// A power-on sweep zeroes every entry before the file reports ready.
module multiport_regfile #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [$clog2(NREGS)-1:0]  waddr,
    input  logic [XLEN-1:0]           wdata,
    input  logic [$clog2(NREGS)-1:0]  raddr1,
    input  logic [$clog2(NREGS)-1:0]  raddr2,
    output logic [XLEN-1:0]           rdata1,
    output logic [XLEN-1:0]           rdata2,
    input  logic                      rsv,
    input  logic [$clog2(NREGS)-1:0]  rsv_addr,
    output logic                      pend1,
    output logic                      pend2,
    output logic                      ready
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [AW-1:0]       initCnt;
    logic [AW-1:0]       initCntNext;
    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    pend;
    logic [NREGS-1:0]    pendNext;
    logic                running;
    logic                doWrite;
    logic                doRsv;

    assign running = (state == RUN);
    assign doWrite = running && we;
    assign doRsv   = running && rsv && (rsv_addr != '0);
    assign ready   = running;

    // State and sweep counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= INIT;
            initCnt <= '0;
        end else begin
            state   <= stateNext;
            initCnt <= initCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        initCntNext = initCnt;
        case (state)
            INIT: begin
                initCntNext = initCnt + AW'(1);
                if (initCnt == AW'(NREGS - 1)) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                stateNext = RUN;
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end

    // Storage has no reset; only the INIT sweep zeroes it
    always_ff @(posedge clk) begin
        if (!running) begin
            regs[initCnt] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Scoreboard: reserve wins over a same-cycle write to the same entry
    always_comb begin
        pendNext = pend;
        if (doWrite) begin
            pendNext[waddr] = 1'b0;
        end
        if (doRsv) begin
            pendNext[rsv_addr] = 1'b1;
        end
        pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pendNext;
        end
    end

    // Read ports with optional same-cycle forwarding
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        pend1  = pend[raddr1];
        pend2  = pend[raddr2];
        if ((BYPASS != 0) && doWrite && (waddr == raddr1)) begin
            rdata1 = wdata;
            if (!(rsv && (rsv_addr == raddr1))) begin
                pend1 = 1'b0;
            end
        end
        if ((BYPASS != 0) && doWrite && (waddr == raddr2)) begin
            rdata2 = wdata;
            if (!(rsv && (rsv_addr == raddr2))) begin
                pend2 = 1'b0;
            end
        end
        if (!running || (raddr1 == '0)) begin
            rdata1 = '0;
        end
        if (!running || (raddr2 == '0)) begin
            rdata2 = '0;
        end
        if (!running) begin
            pend1 = 1'b0;
            pend2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Random and directed bench for multiport_regfile; a bypassing and a
// non-bypassing instance share stimulus and are checked against one model.
module tb_multiport_regfile;

    localparam int unsigned NREGS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        rsv;
    logic [4:0]  rsvAddr;
    logic [31:0] rdata1, rdata2, rdata1B0, rdata2B0;
    logic        pend1, pend2, pend1B0, pend2B0;
    logic        ready, readyB0;

    int unsigned nChecks = 0;
    int unsigned nFails  = 0;

    // Reference model state
    logic [31:0] mRegs [NREGS];
    bit          mPend [NREGS];
    bit          mRun   = 1'b0;
    int          mLeft  = 0;
    bit          mKnown = 1'b0;

    always #5 clk = ~clk;

    multiport_regfile #(.XLEN(32), .NREGS(NREGS), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .rsv(rsv), .rsv_addr(rsvAddr), .pend1(pend1), .pend2(pend2), .ready(ready)
    );

    multiport_regfile #(.XLEN(32), .NREGS(NREGS), .BYPASS(0)) dutB0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1B0), .rdata2(rdata2B0),
        .rsv(rsv), .rsv_addr(rsvAddr), .pend1(pend1B0), .pend2(pend2B0), .ready(readyB0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] expData(input bit byp, input logic [4:0] a);
        if (!mRun || a == 5'd0) return 32'd0;
        if (byp && we && waddr == a) return wdata;
        return mRegs[a];
    endfunction

    function automatic logic expPend(input bit byp, input logic [4:0] a);
        if (!mRun) return 1'b0;
        if (byp && we && waddr == a && !(rsv && rsvAddr == a)) return 1'b0;
        return mPend[a];
    endfunction

    // One clock: drive, check the combinational view, then advance the model
    task automatic cycle(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2, input logic rs, input logic [4:0] ra);
        @(negedge clk);
        rst_n = r; we = w; waddr = wa; wdata = wd;
        raddr1 = a1; raddr2 = a2; rsv = rs; rsvAddr = ra;
        #1;
        if (mKnown) begin
            check("ready",    64'(ready),    64'(mRun));
            check("ready_b0", 64'(readyB0),  64'(mRun));
            check("rdata1",   64'(rdata1),   64'(expData(1'b1, a1)));
            check("rdata2",   64'(rdata2),   64'(expData(1'b1, a2)));
            check("pend1",    64'(pend1),    64'(expPend(1'b1, a1)));
            check("pend2",    64'(pend2),    64'(expPend(1'b1, a2)));
            check("rdata1_b0", 64'(rdata1B0), 64'(expData(1'b0, a1)));
            check("rdata2_b0", 64'(rdata2B0), 64'(expData(1'b0, a2)));
            check("pend1_b0",  64'(pend1B0),  64'(expPend(1'b0, a1)));
            check("pend2_b0",  64'(pend2B0),  64'(expPend(1'b0, a2)));
        end
        @(posedge clk);
        if (!r) begin
            mKnown = 1'b1;
            mRun   = 1'b0;
            mLeft  = NREGS;
            for (int i = 0; i < NREGS; i++) begin
                mRegs[i] = 32'd0;
                mPend[i] = 1'b0;
            end
        end else if (mKnown && !mRun) begin
            mLeft--;
            if (mLeft == 0) mRun = 1'b1;
        end else if (mKnown) begin
            if (w && wa != 5'd0) mRegs[wa] = wd;
            if (w) mPend[wa] = 1'b0;
            if (rs && ra != 5'd0) mPend[ra] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0);
    endtask

    initial begin
        int lowCycles;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; rsv = 1'b0; rsvAddr = '0;

        // Reset, then writes and reserves during the sweep must be ignored
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0);
        lowCycles = 0;
        for (int i = 0; i < 40 && !mRun; i++) begin
            if (!ready) lowCycles++;
            cycle(1'b1, 1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i), 1'b1, 5'(i));
        end
        check("init_len", 64'(lowCycles), 64'(NREGS));
        for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1));

        // Basic write/read and address-0 discard
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 5'd0);
        idle(5'd5, 5'd5);
        cycle(1'b1, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0);
        idle(5'd0, 5'd5);

        // Forwarding versus old value
        cycle(1'b1, 1'b1, 5'd7, 32'h11111111, 5'd1, 5'd2, 1'b0, 5'd0);
        cycle(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 1'b0, 5'd0);
        idle(5'd7, 5'd7);

        // Scoreboard set, clear, and set-wins collision
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9);
        idle(5'd9, 5'd9);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9);
        cycle(1'b1, 1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd9, 1'b0, 5'd0);
        idle(5'd9, 5'd9);
        cycle(1'b1, 1'b1, 5'd9, 32'h0BAD0009, 5'd9, 5'd9, 1'b1, 5'd9);
        idle(5'd9, 5'd9);

        // Reset during RUN restarts the sweep
        cycle(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd4, 1'b1, 5'd4);
        idle(5'd3, 5'd4);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, 5'd0);
        for (int i = 0; i < 34; i++) idle(5'd3, 5'd4);

        // Randomised traffic with rare resets
        for (int n = 0; n < 1500; n++) begin
            logic r;
            r = ($urandom_range(0, 299) != 0);
            cycle(r, 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of 2, at least 4; AW = log2(NREGS).
REQ-003 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding in the same cycle.
REQ-004 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port we, input, 1, write enable.
REQ-007 SHALL have port waddr, input, AW, write address.
REQ-008 SHALL have port wdata, input, XLEN, write data.
REQ-009 SHALL have ports raddr1 and raddr2, input, AW each, read addresses.
REQ-010 SHALL have ports rdata1 and rdata2, output, XLEN each, read data.
REQ-011 SHALL have port rsv, input, 1, reserve request: marks a register as pending a future write.
REQ-012 SHALL have port rsv_addr, input, AW, register to reserve.
REQ-013 SHALL have ports pend1 and pend2, output, 1 each; high when the register at raddr1 or raddr2 is pending.
REQ-014 SHALL have port ready, output, 1; high once initialisation completes.

Function
REQ-015 SHALL implement a two-state FSM: INIT and RUN.
REQ-016 INIT SHALL clear one entry per cycle from a counter running 0 to NREGS-1; after clearing entry NREGS-1 it SHALL go to RUN on the next edge.
REQ-017 ready SHALL be 1 only in RUN; INIT therefore lasts exactly NREGS cycles after rst_n is sampled high.
REQ-018 In INIT: we and rsv SHALL be ignored; rdata1/2 SHALL read 0; pend1/2 SHALL read 0.
REQ-019 In RUN: when we=1 and waddr!=0, regs[waddr] SHALL take wdata at the edge.
REQ-020 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0 in all cases.
REQ-021 Reads SHALL be combinational: rdata = regs[raddr].
REQ-022 With BYPASS=1, when we=1, waddr==raddrN and raddrN!=0, rdataN SHALL equal wdata in the same cycle; with BYPASS=0, rdataN SHALL return the old value.
REQ-023 Both read ports SHALL be independent; the same address on both ports SHALL return identical data.
REQ-024 The block SHALL keep a pending bit per register, NREGS bits; bit 0 SHALL be constant 0.
REQ-025 In RUN, rsv=1 with rsv_addr!=0 SHALL set pend[rsv_addr] at the edge.
REQ-026 In RUN, we=1 SHALL clear pend[waddr] at the edge.
REQ-027 If rsv and we target the same address in the same cycle, set SHALL win and the bit SHALL end at 1; the data write still occurs.
REQ-028 pendN SHALL equal pend[raddrN], except with BYPASS=1 when a same-cycle write to raddrN without a same-address rsv SHALL force pendN to 0.
REQ-029 Reserving an already-pending register SHALL leave it pending, with no error or count.

Reset
REQ-030 While rst_n=0 at an edge: state SHALL become INIT, the counter SHALL become 0, all pending bits SHALL clear, and ready SHALL be 0 in the following cycle.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the full NREGS-cycle clear; register contents are not guaranteed until ready=1.
REQ-032 Register storage SHALL NOT be reset by rst_n directly; only the INIT sweep clears it.

Verification
REQ-033 Reset release: hold rst_n low for 2 cycles, then release -> ready=0 for exactly 32 cycles then 1; reads of registers 1..31 return 0.
REQ-034 Write and read: write 0xDEADBEEF to reg 5, next cycle read on both ports -> 0xDEADBEEF; write 0x1234 to reg 0 -> reads 0.
REQ-035 Bypass: in the same cycle we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=7 -> rdata1=0xA5A5A5A5 with BYPASS=1, and the old value with BYPASS=0.
REQ-036 Scoreboard: rsv reg 9 -> pend1=1 with raddr1=9 from the next cycle; write reg 9 -> pend1=0 after the edge (0 in the write cycle if BYPASS=1); rsv and we both on reg 9 in one cycle -> stays 1.
REQ-037 Gating: we=1 and rsv=1 during INIT -> no effect, so after ready=1 all registers read 0 and all pend=0.
REQ-038 Reset mid-RUN: write reg 3=0x55, reserve reg 4, pulse rst_n low -> pend cleared immediately; after 32 cycles ready=1 and reg 3 reads 0.
